// File: rtl/mem_access_ctrl.sv
// Initiator for the main_mem data port: takes one CPU read/write at a time,
// drives main_mem for a single access cycle and returns a registered response.
module mem_access_ctrl #(
    parameter int ADDR_W       = 8,
    parameter int DATA_W       = 8,
    parameter int MEM_DEPTH    = 3,
    parameter int STATE_MEMORY = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [1:0]        req_op,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_err,
    output logic [2:0]        mem_state,
    output logic [ADDR_W-1:0] mem_address,
    output logic [1:0]        mem_op,
    output logic [DATA_W-1:0] mem_store_value,
    input  logic [DATA_W-1:0] mem_load_value
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACCESS = 2'd1;
    localparam logic [1:0] S_LOAD   = 2'd2;
    localparam logic [1:0] S_RESP   = 2'd3;

    localparam logic [1:0]      OP_READ = 2'b00;
    localparam logic [2:0]      MEM_EN  = 3'(STATE_MEMORY);
    // one extra bit so MEM_DEPTH == 2**ADDR_W still compares correctly
    localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(MEM_DEPTH);

    logic [1:0]        state_q, state_d;
    logic [1:0]        op_q, op_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              err_q, err_d;
    logic              req_bad;

    // ops 2'b10/2'b11 are illegal, as is anything past the last implemented word
    assign req_bad = ({1'b0, req_addr} >= DEPTH_C) || req_op[1];

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    op_d    = req_op;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    rdata_d = '0;
                    err_d   = req_bad;
                    state_d = req_bad ? S_RESP : S_ACCESS;
                end
            end
            S_ACCESS: state_d = (op_q == OP_READ) ? S_LOAD : S_RESP;
            S_LOAD: begin
                // main_mem registers load_value on the ACCESS closing edge
                rdata_d = mem_load_value;
                state_d = S_RESP;
            end
            S_RESP: begin
                if (resp_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            op_q    <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    assign req_ready       = (state_q == S_IDLE);
    assign resp_valid      = (state_q == S_RESP);
    assign resp_rdata      = rdata_q;
    assign resp_err        = err_q;
    assign mem_state       = (state_q == S_ACCESS) ? MEM_EN : 3'd0;
    assign mem_address     = addr_q;
    assign mem_op          = op_q;
    assign mem_store_value = wdata_q;

endmodule

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
- Initiator side of the `main_mem` data-memory interface.
- Accepts single read/write requests from the CPU datapath over a valid/ready handshake.
- Drives `main_mem`'s state/address/op/store_value inputs for exactly one memory cycle, and captures `load_value` on reads.
- Returns a response over a valid/ready handshake. Out-of-range addresses and illegal ops are rejected with an error response and no memory access.

Parameters:
- ADDR_W, 8, address width (matches main_mem address port)
- DATA_W, 8, data width
- MEM_DEPTH, 3, number of implemented words; legal addresses are 0..MEM_DEPTH-1
- STATE_MEMORY, 4, value driven on mem_state to enable a main_mem access

Ports:
- clk  in  1  system clock; all logic on posedge
- reset  in  1  synchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  controller can accept a request
- req_op  in  2  2'b00 read, 2'b01 write, others illegal
- req_addr  in  ADDR_W  word address
- req_wdata  in  DATA_W  write data
- resp_valid  out  1  response present
- resp_ready  in  1  datapath accepts response
- resp_rdata  out  DATA_W  read data; 0 for writes and errors
- resp_err  out  1  request was rejected (bad address or op)
- mem_state  out  3  to main_mem state; STATE_MEMORY only during ACCESS, else 3'd0
- mem_address  out  ADDR_W  to main_mem address
- mem_op  out  2  to main_mem op
- mem_store_value  out  DATA_W  to main_mem store_value
- mem_load_value  in  DATA_W  from main_mem load_value (registered in main_mem)

Behaviour:
- Clocking: one clock (clk). Reset is synchronous, active-high (reset).
- All outputs are registered or decoded from the state register; there are no combinational paths from inputs to outputs.
- Reset values: state IDLE, req_ready=1, resp_valid=0, resp_err=0, resp_rdata=0, mem_state=0, mem_address=0, mem_op=2'b00, mem_store_value=0.
- FSM states: IDLE, ACCESS, LOAD, RESP.
- IDLE:
  - req_ready=1.
  - On posedge with req_valid=1, latch op/addr/wdata.
  - If addr >= MEM_DEPTH or op is not 00/01, go to RESP with resp_err=1 and resp_rdata=0. mem_state never reaches STATE_MEMORY for this request.
  - Otherwise go to ACCESS.
- ACCESS (exactly one cycle):
  - mem_state=STATE_MEMORY; mem_address, mem_op and mem_store_value come from the latched request. main_mem performs the access on the closing edge.
  - Read: go to LOAD. Write: go to RESP with resp_rdata=0 and resp_err=0.
- LOAD (one cycle):
  - mem_state=0; mem_load_value is valid during this cycle.
  - On the closing edge, register it into resp_rdata and go to RESP.
- RESP:
  - resp_valid=1, with resp_rdata and resp_err held stable until resp_ready=1.
  - On posedge with resp_ready=1, drop resp_valid and return to IDLE.
  - A new request can be accepted on the cycle after the return to IDLE. There is no same-edge turnaround.
- Latency, counting accept edge as E0:
  - Read: resp_valid first high after E2.
  - Write: resp_valid first high after E1.
  - Error: resp_valid first high after E0.
- Throughput: one transaction in flight; req_ready=0 in ACCESS, LOAD and RESP.
- Outside ACCESS, mem_op must not be 2'b01 together with mem_state=STATE_MEMORY. In every non-ACCESS cycle, mem_state=0.
- Stalls: req_valid held while req_ready=0 is ignored and not queued. Request fields may change freely after acceptance.
- resp_ready held high while idle has no effect.
- Reset mid-operation (any state): the next edge returns to IDLE with all outputs at reset values and the in-flight response discarded.
  - If reset is asserted during ACCESS, the memory access on that edge still occurs, because main_mem has no reset. This is expected.
- Address compare is unsigned over the full ADDR_W. addr=MEM_DEPTH-1 is legal; addr=MEM_DEPTH is an error.

Test Plan:
- Reset, then read addr 0 with main_mem preload {0xEC, 0x0A, 0x02}
  -> mem_state=4 for exactly one cycle; resp_valid after E2 with resp_rdata=0xEC, resp_err=0.
- Write addr 2 data 0x5A, then read addr 2
  -> write resp after E1 with rdata=0; read returns 0x5A. Addresses 0 and 1 still read 0xEC and 0x0A.
- Read addr 3, then req_op=2'b11 at addr 1
  -> both give resp_err=1, rdata=0, response after E0; mem_state stays 0 throughout.
- Read addr 1 with resp_ready held low 5 cycles
  -> resp_valid, rdata=0x0A and req_ready=0 stay stable all 5 cycles; req_valid pulses in that window are ignored. The response completes on the first resp_ready=1 edge.
- Write addr 1 data 0xFF with reset asserted in the ACCESS cycle
  -> next cycle IDLE, resp_valid=0, req_ready=1. A following read of addr 1 returns 0xFF.
- Back-to-back requests with req_valid and resp_ready tied high
  -> read/write/read sequence completes in order. There is exactly one idle-accept cycle between responses, and one mem_state=4 pulse per legal request.
